// File: rtl/act_quant_pipeline.sv
// Activation -> normalisation -> quantisation pipeline, applied independently per lane.
// Latency: 3 cycles from accepted input beat to out_valid; one beat per cycle throughput.
// Backpressure: a single global advance stalls every stage while out_valid && !out_ready.
module act_quant_pipeline #(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic                   in_last,
  input  logic [1:0]             act_mode,
  input  logic [4:0]             leaky_shift,
  input  logic [ACC_W-1:0]       act_cap,
  input  logic [15:0]            norm_gain,
  input  logic [4:0]             norm_shift,
  input  logic [ACC_W-1:0]       norm_bias,
  input  logic [15:0]            q_inv_scale,
  input  logic [OUT_W-1:0]       q_zero_point,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [CNT_W-1:0]       sat_count,
  input  logic                   sat_clr
);

  // Internal arithmetic width: holds the full product plus bias/rounding without overflow.
  localparam int PW = ACC_W + 18;

  localparam logic signed [PW-1:0] ACC_MAX = {{(PW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [PW-1:0] ACC_MIN = {{(PW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [PW-1:0] OUT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] OUT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [PW-1:0] RND     = {{(PW-9){1'b0}}, 9'd128};

  // Activation for one lane.
  function automatic logic [ACC_W-1:0] act_f(input logic signed [ACC_W-1:0] x,
                                             input logic [1:0]               mode,
                                             input logic [4:0]               sh,
                                             input logic signed [ACC_W-1:0] cap);
    logic [ACC_W-1:0] y;
    case (mode)
      2'd0:    y = x;
      2'd1:    y = x[ACC_W-1] ? '0 : x;
      2'd2:    y = x[ACC_W-1] ? (x >>> sh) : x;
      default: y = x[ACC_W-1] ? '0 : ((x > cap) ? cap : x);
    endcase
    return y;
  endfunction

  // Gain, shift and bias at full precision, then clip back to the accumulator range.
  function automatic logic [ACC_W-1:0] norm_f(input logic signed [ACC_W-1:0] x,
                                              input logic signed [15:0]      gain,
                                              input logic [4:0]              sh,
                                              input logic signed [ACC_W-1:0] bias);
    logic signed [PW-1:0] xe, ge, be, p;
    logic [ACC_W-1:0] r;
    xe = {{(PW-ACC_W){x[ACC_W-1]}}, x};
    ge = {{(PW-16){gain[15]}}, gain};
    be = {{(PW-ACC_W){bias[ACC_W-1]}}, bias};
    p  = (xe * ge) >>> sh;
    p  = p + be;
    if (p > ACC_MAX)      r = ACC_MAX[ACC_W-1:0];
    else if (p < ACC_MIN) r = ACC_MIN[ACC_W-1:0];
    else                  r = p[ACC_W-1:0];
    return r;
  endfunction

  // Q8.8 scale with round-half-up, zero point, clip; MSB of the result is the clip flag.
  function automatic logic [OUT_W:0] quant_f(input logic signed [ACC_W-1:0] x,
                                             input logic signed [15:0]      inv,
                                             input logic signed [OUT_W-1:0] zp);
    logic signed [PW-1:0] xe, se, ze, p;
    logic [OUT_W:0] r;
    xe = {{(PW-ACC_W){x[ACC_W-1]}}, x};
    se = {{(PW-16){inv[15]}}, inv};
    ze = {{(PW-OUT_W){zp[OUT_W-1]}}, zp};
    p  = (xe * se) + RND;
    p  = p >>> 8;
    p  = p + ze;
    if (p > OUT_MAX)      r = {1'b1, OUT_MAX[OUT_W-1:0]};
    else if (p < OUT_MIN) r = {1'b1, OUT_MIN[OUT_W-1:0]};
    else                  r = {1'b0, p[OUT_W-1:0]};
    return r;
  endfunction

  logic                          adv;
  logic                          s1_vld_q, s1_last_q;
  logic [LANES-1:0][ACC_W-1:0]   s1_dat_q, s1_dat_d;
  logic                          s2_vld_q, s2_last_q;
  logic [LANES-1:0][ACC_W-1:0]   s2_dat_q, s2_dat_d;
  logic                          s3_vld_q, s3_last_q, s3_sat_q, s3_sat_d;
  logic [LANES-1:0][OUT_W-1:0]   s3_dat_q, s3_dat_d;
  logic [LANES-1:0][OUT_W:0]     q_res;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  // Whole pipe moves when the output slot is empty or being drained.
  assign adv       = out_ready | ~s3_vld_q;
  assign in_ready  = adv;
  assign out_valid = s3_vld_q;
  assign out_last  = s3_last_q;
  assign out_data  = s3_dat_q;
  assign busy      = s1_vld_q | s2_vld_q | s3_vld_q;
  assign sat_count = cnt_q;

  // S1 combinational: activation on the incoming lanes.
  always_comb begin
    s1_dat_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_dat_d[i] = act_f(in_data[i*ACC_W +: ACC_W], act_mode, leaky_shift, act_cap);
    end
  end

  // S2 combinational: normalisation of the S1 lanes.
  always_comb begin
    s2_dat_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_dat_d[i] = norm_f(s1_dat_q[i], norm_gain, norm_shift, norm_bias);
    end
  end

  // S3 combinational: quantisation of the S2 lanes; any clipped lane marks the beat.
  always_comb begin
    q_res    = '0;
    s3_dat_d = '0;
    s3_sat_d = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      q_res[i]    = quant_f(s2_dat_q[i], q_inv_scale, q_zero_point);
      s3_dat_d[i] = q_res[i][OUT_W-1:0];
      s3_sat_d    = s3_sat_d | q_res[i][OUT_W];
    end
  end

  // Stage registers: all load together on advance, hold otherwise, flush on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_dat_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_dat_q  <= '0;
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      s3_sat_q  <= 1'b0;
      s3_dat_q  <= '0;
    end else if (adv) begin
      s1_vld_q  <= in_valid;
      s1_last_q <= in_last;
      s1_dat_q  <= s1_dat_d;
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_dat_q  <= s2_dat_d;
      s3_vld_q  <= s2_vld_q;
      s3_last_q <= s2_last_q;
      s3_sat_q  <= s3_sat_d;
      s3_dat_q  <= s3_dat_d;
    end
  end

  // Saturation counter next state: clear wins, otherwise count delivered clipped beats, sticky at max.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (s3_vld_q && out_ready && s3_sat_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_act_quant_pipeline.sv
module tb_act_quant_pipeline;
  localparam int LANES = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int CNT_W = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data = '0;
  logic                   in_last = 1'b0;
  logic [1:0]             act_mode = '0;
  logic [4:0]             leaky_shift = '0;
  logic [ACC_W-1:0]       act_cap = '0;
  logic [15:0]            norm_gain = 16'd1;
  logic [4:0]             norm_shift = '0;
  logic [ACC_W-1:0]       norm_bias = '0;
  logic [15:0]            q_inv_scale = 16'h0100;
  logic [OUT_W-1:0]       q_zero_point = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   out_last;
  logic                   busy;
  logic [CNT_W-1:0]       sat_count;
  logic                   sat_clr = 1'b0;

  act_quant_pipeline #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .act_mode(act_mode), .leaky_shift(leaky_shift), .act_cap(act_cap),
    .norm_gain(norm_gain), .norm_shift(norm_shift), .norm_bias(norm_bias),
    .q_inv_scale(q_inv_scale), .q_zero_point(q_zero_point), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   mode;
    logic [4:0]   leaky;
    logic [31:0]  cap;
    logic [15:0]  gain;
    logic [4:0]   nsh;
    logic [31:0]  bias;
    logic [15:0]  inv;
    logic [7:0]   zp;
    logic [127:0] din;
    logic [31:0]  dout;
    logic         sat;
  } vec_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic        sat;
  } exp_t;

  exp_t        q[$];
  vec_t        tv[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          exp_cnt = 0;
  logic        rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic [4:0] leaky, input logic [31:0] cap,
                              input logic [15:0] gain, input logic [4:0] nsh, input logic [31:0] bias,
                              input logic [15:0] inv, input logic [7:0] zp, input logic [127:0] din,
                              input logic [31:0] dout, input logic sat);
    vec_t v;
    v.mode = mode; v.leaky = leaky; v.cap = cap; v.gain = gain; v.nsh = nsh; v.bias = bias;
    v.inv = inv; v.zp = zp; v.din = din; v.dout = dout; v.sat = sat;
    return v;
  endfunction

  task automatic set_cfg(input vec_t v);
    act_mode = v.mode; leaky_shift = v.leaky; act_cap = v.cap; norm_gain = v.gain;
    norm_shift = v.nsh; norm_bias = v.bias; q_inv_scale = v.inv; q_zero_point = v.zp;
  endtask

  // Present one beat at posedge+1; it is pushed to the scoreboard when accepted. Returns at posedge+1.
  task automatic drive_beat(input logic [127:0] d, input logic last, input logic [31:0] e, input logic s);
    logic done;
    exp_t x;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        x.dat = e; x.last = last; x.sat = s;
        q.push_back(x);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) chk("drive_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #1;
      ok = (q.size() == 0) && !busy;
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  // Single beat into an empty pipe; n counts rising edges from acceptance to out_valid.
  task automatic lat_beat(input logic [127:0] d, input logic [31:0] e, output int n);
    drive_beat(d, 1'b0, e, 1'b0);
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Random output backpressure, changed well clear of both clock edges.
  initial forever begin
    @(posedge clk); #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    logic        stall;
    logic [31:0] hold_dat;
    logic        hold_last;
    exp_t        e;
    stall = 1'b0; hold_dat = '0; hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'(out_data), 64'(hold_dat));
          chk("stall_last", 64'(out_last), 64'(hold_last));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat actual=0x%0h required=no_beat", out_data);
          end else begin
            e = q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.dat));
            chk("out_last", 64'(out_last), 64'(e.last));
            n_out++;
            if (e.sat && exp_cnt < CNT_MAX) exp_cnt++;
          end
        end
        stall = out_valid && !out_ready;
        hold_dat = out_data; hold_last = out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idv;
    int   n, base;
    logic [127:0] d;
    logic [31:0]  e;

    idv = mk(2'd0, 5'd0, 32'd0, 16'd1, 5'd0, 32'd0, 16'h0100, 8'd0, '0, '0, 1'b0);
    tv[0] = mk(2'd1, 5'd0, 32'd0, 16'd1, 5'd0, 32'd0, 16'h0100, 8'd0,
               {32'd300, 32'd7, 32'd0, -32'sd5}, {8'h7F, 8'h07, 8'h00, 8'h00}, 1'b1);
    tv[1] = mk(2'd2, 5'd2, 32'd0, 16'd1, 5'd0, 32'd0, 16'h0100, 8'd0,
               {-32'sd1, 32'd5, -32'sd1000, -32'sd16}, {8'hFF, 8'h05, 8'h80, 8'hFC}, 1'b1);
    tv[2] = mk(2'd3, 5'd0, 32'd50, 16'd1, 5'd0, 32'd0, 16'h0080, 8'd10,
               {32'd50, -32'sd9, 32'd3, 32'd100}, {8'd35, 8'd10, 8'd12, 8'd35}, 1'b0);
    tv[3] = mk(2'd0, 5'd0, 32'd0, 16'd1, 5'd0, 32'd0, 16'h0100, 8'd0,
               {-32'sd3, 32'd0, 32'd127, -32'sd128}, {8'hFD, 8'h00, 8'h7F, 8'h80}, 1'b0);
    tv[4] = mk(2'd0, 5'd0, 32'd0, 16'd3, 5'd1, 32'hFFFF_FFF6, 16'h0100, 8'd0,
               {-32'sd1, 32'd100, -32'sd7, 32'd10}, {8'hF4, 8'h7F, 8'hEB, 8'h05}, 1'b1);
    tv[5] = mk(2'd0, 5'd0, 32'd0, 16'h4000, 5'd0, 32'd0, 16'h0001, 8'd0,
               {32'd0, 32'd1, -32'sd1048576, 32'd1048576}, {8'h00, 8'h40, 8'h80, 8'h7F}, 1'b1);
    tv[6] = mk(2'd0, 5'd0, 32'd0, 16'd1, 5'd0, 32'd0, 16'hFF00, 8'hFB,
               {32'd0, 32'd200, -32'sd3, 32'd3}, {8'hFB, 8'h80, 8'hFE, 8'hF8}, 1'b1);
    tv[7] = mk(2'd0, 5'd0, 32'd0, 16'd1, 5'd0, 32'd0, 16'h0100, 8'h7F,
               {-32'sd300, -32'sd255, 32'd0, 32'd1}, {8'h80, 8'h80, 8'h7F, 8'h7F}, 1'b1);

    // Reset state.
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Table of single-beat vectors, each drained before the next configuration.
    for (int i = 0; i < 8; i++) begin
      set_cfg(tv[i]);
      drive_beat(tv[i].din, 1'(i == 7), tv[i].dout, tv[i].sat);
      drain();
      chk($sformatf("sat_count_vec%0d", i), 64'(sat_count), 64'(exp_cnt));
    end

    // Latency into an empty pipe.
    set_cfg(idv);
    lat_beat({32'd4, 32'd3, 32'd2, 32'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, n);
    chk("latency", 64'(n), 64'd3);
    drain();

    // Ten beats under random backpressure; last only on the tenth.
    base = n_out;
    rand_rdy = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int l = 0; l < 4; l++) begin
        d[l*32 +: 32] = 32'(b * 4 + l - 20);
        e[l*8 +: 8]   = 8'(b * 4 + l - 20);
      end
      drive_beat(d, 1'(b == 9), e, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rand_rdy = 1'b0;
    #3 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_delivered", 64'(n_out - base), 64'd10);

    // Drive the counter well past its maximum.
    for (int b = 0; b < CNT_MAX + 8; b++)
      drive_beat({4{32'd1000}}, 1'b0, 32'h7F7F_7F7F, 1'b1);
    drain();
    chk("sat_count_hold", 64'(sat_count), 64'(CNT_MAX));
    chk("sat_count_model", 64'(sat_count), 64'(exp_cnt));

    // Clear coincident with a saturating handshake.
    drive_beat({4{32'd1000}}, 1'b0, 32'h7F7F_7F7F, 1'b1);
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    exp_cnt = 0;
    chk("sat_clr_priority", 64'(sat_count), 64'd0);
    drive_beat({4{32'd1000}}, 1'b0, 32'h7F7F_7F7F, 1'b1);
    drain();
    chk("sat_count_after_clr", 64'(sat_count), 64'(exp_cnt));

    // Reset with three beats in flight.
    for (int b = 1; b <= 3; b++)
      drive_beat({4{32'(b)}}, 1'b0, {4{8'(b)}}, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    lat_beat({32'd9, 32'd8, 32'd7, 32'd6}, {8'd9, 8'd8, 8'd7, 8'd6}, n);
    chk("post_rst_latency", 64'(n), 64'd3);
    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
